// File: rtl/bus_disp_slave.sv
// Memory-mapped LED / 4-digit seven-segment / switch peripheral on the CPU bus.
// Optional macro SW_DEBOUNCE_EN adds a per-bit stable-time filter on the switches.
module bus_disp_slave #(
  parameter int DEV_BIT   = 1,
  parameter int SCAN_DIV  = 50000,
  parameter int DB_CYCLES = 20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] select,
  input  logic        w,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  SW,
  output logic [31:0] rdata,
  output logic        ack,
  output logic [7:0]  led_data,
  output logic [7:0]  segment_data,
  output logic [3:0]  AN
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W  = $clog2(DB_CYCLES + 1);

  logic        sel, wr, rd;
  logic [7:0]  led_q, led_d;
  logic [15:0] seg_q, seg_d;
  logic [7:0]  ctrl_q, ctrl_d;
  logic [31:0] rdata_q, rd_val;
  logic        ack_q;
  logic [2:0]  sw_s1_q, sw_s2_q, sw_stat;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]  dig_q, dig_d;
  logic [3:0]  an_q, an_d;
  logic [7:0]  segd_q, segd_d;
  logic        wrap;
  logic [3:0]  nib;
  logic        unused_bits;

  assign unused_bits = ^{select, addr[31:4], addr[1:0], wdata[31:16]};

  // Active-low {g,f,e,d,c,b,a} pattern for one hex digit.
  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
  endfunction

  assign sel = select[DEV_BIT];
  assign wr  = sel & w;
  assign rd  = sel & ~w;

  always_comb begin
    led_d  = led_q;
    seg_d  = seg_q;
    ctrl_d = ctrl_q;
    if (wr) begin
      case (addr[3:2])
        2'd0:    led_d  = wdata[7:0];
        2'd1:    seg_d  = wdata[15:0];
        2'd3:    ctrl_d = wdata[7:0] & 8'hF1;
        default: ;
      endcase
    end
  end

  always_comb begin
    case (addr[3:2])
      2'd0:    rd_val = {24'd0, led_q};
      2'd1:    rd_val = {16'd0, seg_q};
      2'd2:    rd_val = {29'd0, sw_stat};
      default: rd_val = {24'd0, ctrl_q};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q   <= 8'h00;
      seg_q   <= 16'h0000;
      ctrl_q  <= 8'h01;
      rdata_q <= 32'd0;
      ack_q   <= 1'b0;
    end else begin
      led_q  <= led_d;
      seg_q  <= seg_d;
      ctrl_q <= ctrl_d;
      ack_q  <= sel;
      if (rd) rdata_q <= rd_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_s1_q <= 3'b000;
      sw_s2_q <= 3'b000;
    end else begin
      sw_s1_q <= SW;
      sw_s2_q <= sw_s1_q;
    end
  end

`ifdef SW_DEBOUNCE_EN
  logic [2:0]      db_q;
  logic [DB_W-1:0] db_cnt_q [3];

  // A bit's counter runs only while its synchronized value disagrees with the status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_q <= 3'b000;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sw_s2_q[i] == db_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_W'(DB_CYCLES - 1)) begin
          db_q[i]     <= sw_s2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign sw_stat = db_q;
`else
  assign sw_stat = sw_s2_q;
`endif

  // The glyph is latched only when the digit advances, from post-write register values.
  always_comb begin
    wrap   = (cnt_q == CNT_W'(SCAN_DIV - 1));
    cnt_d  = wrap ? '0 : cnt_q + 1'b1;
    dig_d  = wrap ? dig_q + 2'd1 : dig_q;
    nib    = seg_d[{dig_d, 2'b00} +: 4];
    an_d   = an_q;
    segd_d = segd_q;
    if (wrap) begin
      if (ctrl_d[0]) begin
        an_d   = ~(4'b0001 << dig_d);
        segd_d = {~ctrl_d[4 + dig_d], glyph(nib)};
      end else begin
        an_d   = 4'hF;
        segd_d = 8'hFF;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      dig_q  <= 2'd0;
      an_q   <= 4'hE;
      segd_q <= 8'hC0;
    end else begin
      cnt_q  <= cnt_d;
      dig_q  <= dig_d;
      an_q   <= an_d;
      segd_q <= segd_d;
    end
  end

  assign rdata        = rdata_q;
  assign ack          = ack_q;
  assign led_data     = led_q;
  assign segment_data = segd_q;
  assign AN           = an_q;

endmodule
